jtag_source_sync: RTL

//  Downstream consumer of the JTAG source/probe register, in the system clock domain.
//  - source_async: tck-domain source bus, updated on JTAG Update-DR.
//  - Synchronizes source_async into clk and filters out multi-bit skew.
//  - Commits a new value only after it has been stable; emits a one-cycle update pulse.
//  - Registers the system status word fed back to the JTAG probe; freeze holds it coherent.

---
 rtl/jtag_source_sync.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/jtag_source_sync.sv
// Purpose : clk-domain consumer of the JTAG source/probe register; synchronizes and
//           debounces the tck-domain source bus, and registers the status word read back.
// Latency : source_async -> source_sync/source_valid in SYNC_STAGES+STABLE_CYCLES+1 clocks.
// Backpr. : none; source_valid is a one-cycle pulse and there is no ready input.
//
// Ports:
//   clk          system clock, the only clock in this block
//   reset        asynchronous, active-high reset
//   source_async JTAG source bus, asynchronous to clk
//   sys_status   system status word to be read back over JTAG
//   freeze       1 = hold probe at its current value
//   source_sync  filtered, committed source value
//   source_valid one-cycle pulse when source_sync has just been updated
//   probe        registered status word, to the JTAG probe input
//   busy         1 while a candidate value is settling or being committed
module jtag_source_sync #(
    parameter int Dw            = 2,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [Dw-1:0] source_async,
    input  logic [Dw-1:0] sys_status,
    input  logic          freeze,
    output logic [Dw-1:0] source_sync,
    output logic          source_valid,
    output logic [Dw-1:0] probe,
    output logic          busy
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [Dw-1:0] sync_q [SYNC_STAGES];
    logic [Dw-1:0] sync_d [SYNC_STAGES];
    logic [Dw-1:0] cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [Dw-1:0] source_sync_q, source_sync_d;
    logic          source_valid_q, source_valid_d;
    logic          busy_q, busy_d;
    logic [Dw-1:0] probe_q, probe_d;

    logic [Dw-1:0] s;
    logic          cand_match;
    logic          cnt_last;
    logic          commit_new;

    // Synchronizer chain: plain shift of the raw bus. Multi-bit skew across the
    // bits is tolerated because the FSM only accepts a value after it has been
    // seen unchanged for STABLE_CYCLES consecutive samples.
    always_comb begin
        sync_d[0] = source_async;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign s          = sync_q[SYNC_STAGES-1];
    assign cand_match = (s == cand_q);
    assign cnt_last   = (cnt_q == CNT_LAST);
    // A settled candidate equal to the committed value means the bus bounced
    // back; that case returns to IDLE silently.
    assign commit_new = (state_q == ST_SETTLE) && cand_match && cnt_last
                        && (cand_q != source_sync_q);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, including the candidate/stability counter
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (s != source_sync_q) begin
                    state_d = ST_SETTLE;
                    cand_d  = s;
                    cnt_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (!cand_match) begin
                    // Glitch or further change: restart the stability count.
                    cand_d = s;
                    cnt_d  = '0;
                end else if (!cnt_last) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (cand_q != source_sync_q) begin
                    state_d = ST_COMMIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                // One-cycle pulse; IDLE re-examines s on the next cycle so a
                // change arriving now is not lost.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic (all outputs registered)
    always_comb begin
        source_sync_d  = source_sync_q;
        source_valid_d = 1'b0;
        busy_d         = (state_d != ST_IDLE);
        if (commit_new) begin
            source_sync_d  = cand_q;
            source_valid_d = 1'b1;
        end
        probe_d = freeze ? probe_q : sys_status;
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            cand_q         <= '0;
            cnt_q          <= '0;
            source_sync_q  <= '0;
            source_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            probe_q        <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            cand_q         <= cand_d;
            cnt_q          <= cnt_d;
            source_sync_q  <= source_sync_d;
            source_valid_q <= source_valid_d;
            busy_q         <= busy_d;
            probe_q        <= probe_d;
        end
    end

    assign source_sync  = source_sync_q;
    assign source_valid = source_valid_q;
    assign busy         = busy_q;
    assign probe        = probe_q;

endmodule
